// File: rtl/writeback_regfile.sv
// Y86-64 writeback stage: 15x64 register file with same-cycle bypass reads,
// a RUN/HALT/FAULT status machine and a saturating retired-instruction counter.
module writeback_regfile #(
  parameter int          CNT_W    = 32,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [63:0]      W_valE,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       W_dstE,
  input  logic [3:0]       W_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] SBUB  = 3'd0;
  localparam logic [2:0] SAOK  = 3'd1;
  localparam logic [2:0] SHLT  = 3'd2;
  localparam logic [2:0] SADR  = 3'd3;
  localparam logic [2:0] SINS  = 3'd4;
  localparam logic [3:0] RNONE = 4'hF;
  localparam int         NREGS = 15;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        stat_q, stat_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [63:0]       regs_q [NREGS];
  logic [63:0]       regs_d [NREGS];
  logic              we;

  // icode only travels with the instruction for observation; it never gates a write
  logic unused_icode;
  assign unused_icode = ^W_icode;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [63:0] read_port(
    input logic [3:0]  src,
    input logic        wen,
    input logic [3:0]  dst_e,
    input logic [3:0]  dst_m,
    input logic [63:0] val_e,
    input logic [63:0] val_m,
    input logic [63:0] regs [NREGS]
  );
    logic [63:0] r;
    r = '0;
    if (src != RNONE) begin
      if (wen && src == dst_m)      r = val_m;
      else if (wen && src == dst_e) r = val_e;
      else begin
        for (int i = 0; i < NREGS; i++) begin
          if (src == 4'(i)) r = regs[i];
        end
      end
    end
    return r;
  endfunction

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      stat_q    <= SAOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    if (state_q == ST_RUN) begin
      case (W_stat)
        SHLT: begin
          state_d = ST_HALT;
          stat_d  = SHLT;
        end
        SADR, SINS: begin
          state_d = ST_FAULT;
          stat_d  = W_stat;
        end
        default: ;
      endcase
    end
    if (we) retired_d = sat_inc(retired_q);
  end

  // ---- outputs ----
  always_comb begin
    we      = (state_q == ST_RUN) && (W_stat == SAOK);
    halted  = (state_q != ST_RUN);
    Stat    = stat_q;
    retired = retired_q;
  end

  // valM takes priority when both destinations name the same register
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && W_dstM == 4'(i))      regs_d[i] = W_valM;
      else if (we && W_dstE == 4'(i)) regs_d[i] = W_valE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    d_rvalA = read_port(d_srcA, we, W_dstE, W_dstM, W_valE, W_valM, regs_q);
    d_rvalB = read_port(d_srcB, we, W_dstE, W_dstM, W_valE, W_valM, regs_q);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a default-width instance plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
module tb_writeback_regfile;

  localparam logic [63:0] RSP = 64'hDEAD_BEEF_0000_1000;

  logic        clk;
  logic        rst_n;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  W_dstE, W_dstM, d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [2:0]  Stat;
  logic        halted;
  logic [31:0] retired;
  logic [63:0] s_rvalA, s_rvalB;
  logic [2:0]  s_Stat;
  logic        s_halted;
  logic [3:0]  s_retired;

  int checks   = 0;
  int failures = 0;

  writeback_regfile #(.CNT_W(32), .RSP_INIT(RSP)) dut (
    .clk(clk), .rst_n(rst_n), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .Stat(Stat), .halted(halted), .retired(retired)
  );

  writeback_regfile #(.CNT_W(4), .RSP_INIT(64'h0)) dut_s (
    .clk(clk), .rst_n(rst_n), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(s_rvalA), .d_rvalB(s_rvalB),
    .Stat(s_Stat), .halted(s_halted), .retired(s_retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; W_stat = 3'd0; W_icode = 4'h0;
    W_valE = '0; W_valM = '0; W_dstE = 4'hF; W_dstM = 4'hF;
    d_srcA = 4'd4; d_srcB = 4'd3;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_stat", Stat, 3'd1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_rsp", d_rvalA, RSP);
    chk("rst_r3", d_rvalB, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single valE write with same-cycle bypass
    W_stat = 3'd1; W_icode = 4'h6; W_dstE = 4'd3; W_valE = 64'h55; W_dstM = 4'hF;
    d_srcA = 4'd3; d_srcB = 4'hF;
    #1;
    chk("byp_e", d_rvalA, 64'h55);
    chk("rnone_read", d_rvalB, 64'h0);
    tick();
    W_stat = 3'd0; W_dstE = 4'hF;
    #1;
    chk("store_r3", d_rvalA, 64'h55);
    chk("retired_1", retired, 32'd1);

    // valE and valM to the same register: valM wins
    W_stat = 3'd1; W_dstE = 4'd4; W_valE = 64'h100; W_dstM = 4'd4; W_valM = 64'h200;
    d_srcB = 4'd4;
    #1;
    chk("byp_m_wins", d_rvalB, 64'h200);
    tick();
    W_stat = 3'd0; W_dstE = 4'hF; W_dstM = 4'hF;
    #1;
    chk("store_r4", d_rvalB, 64'h200);
    chk("retired_2", retired, 32'd2);

    // bubble performs no write
    W_stat = 3'd0; W_dstE = 4'd2; W_valE = 64'h9; d_srcA = 4'd2;
    #1;
    chk("bub_nobyp", d_rvalA, 64'h0);
    tick();
    chk("bub_r2", d_rvalA, 64'h0);
    chk("bub_retired", retired, 32'd2);
    chk("bub_stat", Stat, 3'd1);

    // distinct valE/valM destinations incl. top register 14
    W_stat = 3'd1; W_dstE = 4'd14; W_valE = 64'hAA; W_dstM = 4'd5; W_valM = 64'h77;
    tick();
    W_stat = 3'd0; W_dstE = 4'hF; W_dstM = 4'hF; d_srcA = 4'd14; d_srcB = 4'd5;
    #1;
    chk("store_r14", d_rvalA, 64'hAA);
    chk("store_r5", d_rvalB, 64'h77);
    chk("retired_3", retired, 32'd3);

    // halt, then attempted write is suppressed
    W_stat = 3'd2;
    #1;
    chk("pre_halt_stat", Stat, 3'd1);
    chk("pre_halt_h", halted, 1'b0);
    tick();
    W_stat = 3'd1; W_dstE = 4'd1; W_valE = 64'h11; d_srcA = 4'd1;
    #1;
    chk("halt_stat", Stat, 3'd2);
    chk("halt_h", halted, 1'b1);
    chk("halt_nobyp", d_rvalA, 64'h0);
    tick();
    chk("halt_r1", d_rvalA, 64'h0);
    chk("halt_retired", retired, 32'd3);
    chk("halt_sticky", Stat, 3'd2);

    // async reset mid-cycle out of HALT
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stat", Stat, 3'd1);
    chk("arst_h", halted, 1'b0);
    chk("arst_retired", retired, 32'd0);
    W_dstE = 4'hF; d_srcA = 4'd14; d_srcB = 4'd4;
    #1;
    chk("arst_r14", d_rvalA, 64'h0);
    chk("arst_rsp", d_rvalB, RSP);
    W_stat = 3'd1; W_dstE = 4'd3; W_valE = 64'h99;
    tick();
    W_stat = 3'd0; W_dstE = 4'hF; d_srcA = 4'd3;
    #1;
    chk("rstwr_r3", d_rvalA, 64'h0);
    chk("rstwr_retired", retired, 32'd0);

    // first write lands on the first edge after release
    #1 rst_n = 1'b1;
    W_stat = 3'd1; W_dstE = 4'd6; W_valE = 64'h66;
    tick();
    chk("first_wr_ret", retired, 32'd1);
    W_stat = 3'd4; W_dstE = 4'd7; W_valE = 64'h77; d_srcA = 4'd6; d_srcB = 4'd7;
    #1;
    chk("first_wr_r6", d_rvalA, 64'h66);
    tick();
    chk("fault_stat", Stat, 3'd4);
    chk("fault_h", halted, 1'b1);
    chk("fault_retired", retired, 32'd1);
    chk("fault_r7", d_rvalB, 64'h0);

    // reset out of FAULT clears registers without an edge
    W_stat = 3'd1; W_dstE = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("frst_stat", Stat, 3'd1);
    chk("frst_h", halted, 1'b0);
    chk("frst_r6", d_rvalA, 64'h0);

    // saturation of the narrow counter
    #1 rst_n = 1'b1;
    W_stat = 3'd1; W_dstE = 4'hF; W_dstM = 4'hF;
    repeat (14) tick();
    chk("sat_14", s_retired, 4'hE);
    chk("main_14", retired, 32'd14);
    repeat (3) tick();
    chk("sat_17", s_retired, 4'hF);
    chk("main_17", retired, 32'd17);
    tick();
    chk("sat_hold", s_retired, 4'hF);
    chk("sat_halted", s_halted, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 Parameter RSP_INIT, default 64'h0: reset value of register 4 (%rsp).
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 W_stat  input  3  writeback-stage status: 0 SBUB, 1 SAOK, 2 SHLT, 3 SADR, 4 SINS.
REQ-006 W_icode  input  4  writeback-stage icode; informational only, with no effect on writes.
REQ-007 W_valE  input  64  ALU result to write to W_dstE.
REQ-008 W_valM  input  64  memory result to write to W_dstM.
REQ-009 W_dstE  input  4  destination for valE; 4'hF (RNONE) means no write.
REQ-010 W_dstM  input  4  destination for valM; 4'hF means no write.
REQ-011 d_srcA  input  4  decode read address A.
REQ-012 d_srcB  input  4  decode read address B.
REQ-013 d_rvalA  output  64  combinational read data A.
REQ-014 d_rvalB  output  64  combinational read data B.
REQ-015 Stat  output  3  architectural processor status, registered.
REQ-016 halted  output  1  high when the processor has left the RUN state, registered.
REQ-017 retired  output  CNT_W  count of committed SAOK instructions, registered.

Function
REQ-018 The block SHALL hold 15 registers of 64 bits each, indexed 0..14; index 15 is RNONE and holds no storage.
REQ-019 The state machine SHALL have three states: RUN, HALT and FAULT.
REQ-020 RUN -> HALT SHALL occur on a rising edge when W_stat==SHLT.
REQ-021 RUN -> FAULT SHALL occur on a rising edge when W_stat is SADR or SINS; HALT and FAULT SHALL be sticky until reset.
REQ-022 A write enable SHALL be asserted only when the state is RUN and W_stat==SAOK; SBUB, SHLT, SADR and SINS cycles SHALL perform no register write.
REQ-023 When the write enable is high, reg[W_dstE] SHALL take W_valE at the rising edge if W_dstE!=RNONE.
REQ-024 When the write enable is high, reg[W_dstM] SHALL take W_valM at the rising edge if W_dstM!=RNONE.
REQ-025 If W_dstE==W_dstM!=RNONE, W_valM SHALL win and only W_valM SHALL be written.
REQ-026 Reads SHALL be combinational, with a same-cycle bypass: if the write enable is high and srcX matches W_dstM, the port SHALL return W_valM.
REQ-027 Otherwise, if the write enable is high and srcX matches W_dstE, the port SHALL return W_valE; otherwise it SHALL return reg[srcX].
REQ-028 A read with srcX==RNONE SHALL return 64'h0 regardless of the bypass.
REQ-029 Stat SHALL be SAOK in RUN; on the RUN exit edge it SHALL latch W_stat (SHLT, SADR or SINS) and then hold.
REQ-030 SBUB SHALL never appear on Stat.
REQ-031 halted SHALL be 1 exactly when the state is HALT or FAULT.
REQ-032 retired SHALL increment by 1 on every edge where the write enable condition holds (RUN and W_stat==SAOK), including cycles where both destinations are RNONE.
REQ-033 retired SHALL saturate at all-ones and SHALL NOT wrap.
REQ-034 Write latency SHALL be one edge; the written value SHALL be readable via the bypass in the same cycle and from storage from the next cycle.

Reset
REQ-035 rst_n low SHALL immediately, without waiting for clk, force all registers to 0 except reg[4]=RSP_INIT.
REQ-036 rst_n low SHALL immediately force the state to RUN, Stat=SAOK (3'd1), halted=0 and retired=0.
REQ-037 An assertion of rst_n in HALT or FAULT SHALL return the block to RUN; a write presented on an edge while rst_n is low SHALL be discarded.
REQ-038 Deassertion of rst_n SHALL take effect at the next rising edge; the first write can occur on that edge.

Verification
REQ-039 Reset, then W_stat=1, W_dstE=3, W_valE=64'h55, W_dstM=F, d_srcA=3 -> d_rvalA=64'h55 in the same cycle; reg3=64'h55 after the edge; retired=1.
REQ-040 W_stat=1, W_dstE=4, W_valE=64'h100, W_dstM=4, W_valM=64'h200 -> reg4=64'h200 and d_rvalB(src 4)=64'h200 in the same cycle.
REQ-041 W_stat=0 (bubble), W_dstE=2, W_valE=64'h9 -> reg2 unchanged, retired unchanged, Stat=1.
REQ-042 W_stat=2 for one edge, then W_stat=1, W_dstE=1 writes -> Stat=2, halted=1, reg1 unchanged, retired frozen.
REQ-043 W_stat=4 -> Stat=4, halted=1; then rst_n pulsed low mid-cycle -> Stat=1, halted=0 and registers cleared with no clock edge.
REQ-044 With CNT_W=4, 17 consecutive SAOK cycles -> retired=4'hF, held.
